// File: rtl/zork_text_pkg.sv
// rtl/zork_text_pkg.sv - shared constants, widths and state type for the room text streamer
package zork_text_pkg;

    localparam int POS_W = 8;
    localparam int IDX_W = 8;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EMIT_SPC,
        S_EMIT_CHR,
        S_EMIT_CR,
        S_EMIT_LF,
        S_FINISH
    } stream_state_t;

    function automatic logic [POS_W-1:0] pack_pos(input logic [3:0] x, input logic [3:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/room_text_streamer.sv
// rtl/room_text_streamer.sv - sweeps a room ROM and streams word-wrapped text over valid/ready
module room_text_streamer
    import zork_text_pkg::*;
#(
    parameter int LINE_LEN = 40,
    parameter int END_RUN  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [POS_W-1:0] player_pos,
    output logic [POS_W-1:0] rom_player_pos,
    output logic [IDX_W-1:0] rom_screen_pos,
    input  logic [7:0]       rom_char,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done
);

    localparam logic [7:0] LINE_LEN_B = 8'(LINE_LEN);
    localparam logic [7:0] END_RUN_B  = 8'(END_RUN);

    stream_state_t    state;
    logic [IDX_W-1:0] idx;
    logic [7:0]       spc_cnt;
    logic [7:0]       col;
    logic [7:0]       held;
    logic             chr_pend;
    logic             term;

    logic             xfer;
    logic [7:0]       col_inc;
    logic             wrap;
    logic             last_idx;

    assign xfer           = tx_valid & tx_ready;
    assign col_inc        = col + 8'd1;
    assign wrap           = (col_inc == LINE_LEN_B);
    assign last_idx       = (idx == '1);
    assign rom_screen_pos = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            rom_player_pos <= '0;
            idx            <= '0;
            spc_cnt        <= '0;
            col            <= '0;
            held           <= '0;
            chr_pend       <= 1'b0;
            term           <= 1'b0;
            tx_data        <= '0;
            tx_valid       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rom_player_pos <= player_pos;
                        idx            <= '0;
                        spc_cnt        <= '0;
                        col            <= '0;
                        chr_pend       <= 1'b0;
                        term           <= 1'b0;
                        busy           <= 1'b1;
                        state          <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (rom_char == ASCII_SPACE) begin
                        // Spaces are only counted; they go out later if a printable follows.
                        if ((spc_cnt + 8'd1 == END_RUN_B) || last_idx) begin
                            spc_cnt <= '0;
                            if (col != 8'd0) begin
                                term     <= 1'b1;
                                tx_data  <= ASCII_CR;
                                tx_valid <= 1'b1;
                                state    <= S_EMIT_CR;
                            end else begin
                                state <= S_FINISH;
                            end
                        end else begin
                            spc_cnt <= spc_cnt + 8'd1;
                            idx     <= idx + 1'b1;
                        end
                    end else begin
                        held     <= rom_char;
                        chr_pend <= 1'b1;
                        tx_valid <= 1'b1;
                        if (spc_cnt != 8'd0) begin
                            tx_data <= ASCII_SPACE;
                            state   <= S_EMIT_SPC;
                        end else begin
                            tx_data <= rom_char;
                            state   <= S_EMIT_CHR;
                        end
                    end
                end
                S_EMIT_SPC: begin
                    if (xfer) begin
                        spc_cnt <= spc_cnt - 8'd1;
                        if (wrap) begin
                            col     <= '0;
                            tx_data <= ASCII_CR;
                            state   <= S_EMIT_CR;
                        end else begin
                            col <= col_inc;
                            if (spc_cnt == 8'd1) begin
                                tx_data <= held;
                                state   <= S_EMIT_CHR;
                            end
                        end
                    end
                end
                S_EMIT_CHR: begin
                    if (xfer) begin
                        chr_pend <= 1'b0;
                        if (last_idx) term <= 1'b1;
                        else          idx  <= idx + 1'b1;
                        // The last slot always leaves col non-zero, so it always closes the line.
                        if (wrap || last_idx) begin
                            col     <= '0;
                            tx_data <= ASCII_CR;
                            state   <= S_EMIT_CR;
                        end else begin
                            col      <= col_inc;
                            tx_valid <= 1'b0;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_EMIT_CR: begin
                    if (xfer) begin
                        tx_data <= ASCII_LF;
                        state   <= S_EMIT_LF;
                    end
                end
                S_EMIT_LF: begin
                    if (xfer) begin
                        if (term) begin
                            tx_valid <= 1'b0;
                            state    <= S_FINISH;
                        end else if (spc_cnt != 8'd0) begin
                            tx_data <= ASCII_SPACE;
                            state   <= S_EMIT_SPC;
                        end else if (chr_pend) begin
                            tx_data <= held;
                            state   <= S_EMIT_CHR;
                        end else begin
                            tx_valid <= 1'b0;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
